// File: rtl/control_unit_idex.sv
// rtl/control_unit_idex.sv - RV32 main decode with registered ID/EX execute-stage controls
//
// Decodes instr_d (RV32I, optional MUL, jump and upper-immediate groups) and
// registers every execute-stage control across the ID/EX boundary.
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   instr_d, valid_d         decode-stage instruction and its valid qualifier
//   stall_e, flush_e         hold / bubble the ID/EX register (flush wins)
//   ImmSrcD                  immediate format, combinational from instr_d
//   *E outputs               registered execute-stage controls
//   validE, illegalE         E-stage occupancy and illegal-encoding flag
//   ill_count                saturating count of accepted illegal instructions
module control_unit_idex #(
    parameter bit M_EN      = 1'b0,
    parameter bit JUMP_EN   = 1'b1,
    parameter bit UPPER_EN  = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic [2:0]           ImmSrcD,
    output logic                 RegWriteE,
    output logic                 ALUSrcE,
    output logic                 ALUSrcAE,
    output logic                 MemWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic                 JalrE,
    output logic [2:0]           BranchTypeE,
    output logic [3:0]           ALUControlE,
    output logic                 validE,
    output logic                 illegalE,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [ILL_CNT_W-1:0] CNT_ONE = ILL_CNT_W'(1);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr_d[6:0];
    assign funct3        = instr_d[14:12];
    assign funct7        = instr_d[31:25];
    assign unused_fields = ^{instr_d[24:15], instr_d[11:7]};

    logic       reg_write_d;
    logic       alu_src_d;
    logic       alu_src_a_d;
    logic       mem_write_d;
    logic [1:0] result_src_d;
    logic       branch_d;
    logic       jump_d;
    logic       jalr_d;
    logic [2:0] branch_type_d;
    logic [3:0] alu_control_d;
    logic [2:0] imm_src_d;
    logic       illegal_d;

    // Shared funct3 -> ALU op mapping for the base-encoding OP and OP-IMM forms.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        reg_write_d   = 1'b0;
        alu_src_d     = 1'b0;
        alu_src_a_d   = 1'b0;
        mem_write_d   = 1'b0;
        result_src_d  = RES_ALU;
        branch_d      = 1'b0;
        jump_d        = 1'b0;
        jalr_d        = 1'b0;
        branch_type_d = 3'b000;
        alu_control_d = ALU_ADD;
        imm_src_d     = IMM_I;
        illegal_d     = 1'b0;

        case (opcode)
            OP_LOAD: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = RES_MEM;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm_src_d   = IMM_S;
            end
            OP_REG: begin
                reg_write_d = 1'b1;
                if (funct7 == F7_BASE)
                    alu_control_d = alu_from_funct3(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    alu_control_d = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    alu_control_d = ALU_SRA;
                else if (funct7 == F7_MULD && M_EN)
                    alu_control_d = ALU_MUL;
                else
                    illegal_d = 1'b1;
            end
            OP_IMM: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                // Only the shift forms constrain the upper immediate bits.
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) alu_control_d = ALU_SLL;
                        else                   illegal_d     = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     alu_control_d = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_control_d = ALU_SRA;
                        else                       illegal_d     = 1'b1;
                    end
                    default: alu_control_d = alu_from_funct3(funct3);
                endcase
            end
            OP_BRANCH: begin
                branch_d      = 1'b1;
                imm_src_d     = IMM_B;
                branch_type_d = funct3;
                case (funct3)
                    3'b000, 3'b001: alu_control_d = ALU_SUB;
                    3'b100, 3'b101: alu_control_d = ALU_SLT;
                    3'b110, 3'b111: alu_control_d = ALU_SLTU;
                    default:        illegal_d     = 1'b1;
                endcase
            end
            OP_JAL: begin
                if (JUMP_EN) begin
                    reg_write_d  = 1'b1;
                    jump_d       = 1'b1;
                    result_src_d = RES_PC4;
                    imm_src_d    = IMM_J;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_JALR: begin
                if (JUMP_EN && funct3 == 3'b000) begin
                    reg_write_d  = 1'b1;
                    jump_d       = 1'b1;
                    jalr_d       = 1'b1;
                    alu_src_d    = 1'b1;
                    result_src_d = RES_PC4;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_LUI: begin
                if (UPPER_EN) begin
                    reg_write_d   = 1'b1;
                    alu_src_d     = 1'b1;
                    alu_control_d = ALU_PASSB;
                    imm_src_d     = IMM_U;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (UPPER_EN) begin
                    reg_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                    alu_src_a_d = 1'b1;
                    imm_src_d   = IMM_U;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: illegal_d = 1'b1;
        endcase

        // An illegal encoding must not leak any partially decoded control.
        if (illegal_d) begin
            reg_write_d   = 1'b0;
            alu_src_d     = 1'b0;
            alu_src_a_d   = 1'b0;
            mem_write_d   = 1'b0;
            result_src_d  = RES_ALU;
            branch_d      = 1'b0;
            jump_d        = 1'b0;
            jalr_d        = 1'b0;
            branch_type_d = 3'b000;
            alu_control_d = ALU_ADD;
            imm_src_d     = IMM_I;
        end
    end

    assign ImmSrcD = imm_src_d;

    // ID/EX register: rst and flush load a bubble, stall holds, otherwise load.
    // A load with valid_d low is also a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_e || (!stall_e && !valid_d)) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUSrcAE    <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= RES_ALU;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            JalrE       <= 1'b0;
            BranchTypeE <= 3'b000;
            ALUControlE <= ALU_ADD;
            validE      <= 1'b0;
            illegalE    <= 1'b0;
        end else if (!stall_e) begin
            RegWriteE   <= reg_write_d;
            ALUSrcE     <= alu_src_d;
            ALUSrcAE    <= alu_src_a_d;
            MemWriteE   <= mem_write_d;
            ResultSrcE  <= result_src_d;
            BranchE     <= branch_d;
            JumpE       <= jump_d;
            JalrE       <= jalr_d;
            BranchTypeE <= branch_type_d;
            ALUControlE <= alu_control_d;
            validE      <= 1'b1;
            illegalE    <= illegal_d;
        end
    end

    // Counts only instructions that actually enter E; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_count <= '0;
        end else if (!flush_e && !stall_e && valid_d && illegal_d && (ill_count != '1)) begin
            ill_count <= ill_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_control_unit_idex.sv
// tb/tb_control_unit_idex.sv - self-checking bench for control_unit_idex against a table-driven decode model
module tb_control_unit_idex;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_d = 32'h0;
    logic        valid_d = 1'b0;
    logic        stall_e = 1'b0;
    logic        flush_e = 1'b0;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Three configurations: defaults, 2-bit counter, MUL on with jump/upper off.
    localparam bit [2:0] CFG_M = 3'b100;
    localparam bit [2:0] CFG_J = 3'b011;
    localparam bit [2:0] CFG_U = 3'b011;
    int cnt_max [3] = '{255, 3, 255};

    // {RegWrite,ALUSrc,ALUSrcA,MemWrite,ResultSrc[2],Branch,Jump,Jalr,BranchType[3],ALUControl[4],valid,illegal}
    logic [17:0] obs_e   [3];
    logic [2:0]  obs_imm [3];
    int          obs_cnt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 1) ? 2 : 8;
        logic [W-1:0] cnt;
        logic [17:0]  e;
        logic [2:0]   imm;
        control_unit_idex #(
            .M_EN(CFG_M[g]), .JUMP_EN(CFG_J[g]), .UPPER_EN(CFG_U[g]), .ILL_CNT_W(W)
        ) u_dut (
            .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
            .stall_e(stall_e), .flush_e(flush_e), .ImmSrcD(imm),
            .RegWriteE(e[17]), .ALUSrcE(e[16]), .ALUSrcAE(e[15]), .MemWriteE(e[14]),
            .ResultSrcE(e[13:12]), .BranchE(e[11]), .JumpE(e[10]), .JalrE(e[9]),
            .BranchTypeE(e[8:6]), .ALUControlE(e[5:2]), .validE(e[1]), .illegalE(e[0]),
            .ill_count(cnt)
        );
        assign obs_e[g]   = e;
        assign obs_imm[g] = imm;
        assign obs_cnt[g] = int'(cnt);
    end

    typedef struct packed {
        logic       rw, asrc, asrca, mw;
        logic [1:0] res;
        logic       br, jmp, jalr;
        logic [2:0] bt;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       ill;
    } dec_t;

    logic [17:0] exp_e   [3] = '{18'h0, 18'h0, 18'h0};
    int          exp_cnt [3] = '{0, 0, 0};

    // Reference decode: instruction classes with their control sets, base ALU ops from a table.
    function automatic dec_t model(input logic [31:0] ins, input bit m_en, input bit j_en, input bit u_en);
        dec_t d;
        logic [3:0] alu_tab [8];
        logic [6:0] f7;
        logic [2:0] f3;
        bit bad;
        alu_tab = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
        f7 = ins[31:25];
        f3 = ins[14:12];
        d = '0;
        bad = 0;
        case (ins[6:0])
            7'h03: begin d.rw = 1; d.asrc = 1; d.res = 2'd1; end
            7'h23: begin d.mw = 1; d.asrc = 1; d.imm = 3'd1; end
            7'h33: begin
                d.rw = 1;
                if (f7 == 7'h00)                  d.alu = alu_tab[f3];
                else if (f7 == 7'h20 && f3 == 0)  d.alu = 4'h1;
                else if (f7 == 7'h20 && f3 == 5)  d.alu = 4'h9;
                else if (f7 == 7'h01 && m_en)     d.alu = 4'hB;
                else bad = 1;
            end
            7'h13: begin
                d.rw = 1; d.asrc = 1;
                if (f3 == 1 && f7 != 0)                    bad = 1;
                else if (f3 == 5 && f7 == 7'h20)           d.alu = 4'h9;
                else if (f3 == 5 && f7 != 0)               bad = 1;
                else                                       d.alu = alu_tab[f3];
            end
            7'h63: begin
                d.br = 1; d.imm = 3'd2; d.bt = f3;
                if (f3 == 2 || f3 == 3) bad = 1;
                else d.alu = (f3 < 2) ? 4'h1 : (f3 < 6) ? 4'h5 : 4'h6;
            end
            7'h6F: begin
                if (!j_en) bad = 1;
                d.rw = 1; d.jmp = 1; d.res = 2'd2; d.imm = 3'd3;
            end
            7'h67: begin
                if (!j_en || f3 != 0) bad = 1;
                d.rw = 1; d.jmp = 1; d.jalr = 1; d.asrc = 1; d.res = 2'd2;
            end
            7'h37: begin
                if (!u_en) bad = 1;
                d.rw = 1; d.asrc = 1; d.alu = 4'hA; d.imm = 3'd4;
            end
            7'h17: begin
                if (!u_en) bad = 1;
                d.rw = 1; d.asrc = 1; d.asrca = 1; d.imm = 3'd4;
            end
            default: bad = 1;
        endcase
        if (bad) begin
            d = '0;
            d.ill = 1;
        end
        return d;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] x;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        x = $urandom;
        case ($urandom_range(0, 3))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            2: x[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 9) != 0) x[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) x[14:12] = 3'b000;
        return x;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic st, input logic fl);
        dec_t d;
        rst = r; instr_d = ins; valid_d = v; stall_e = st; flush_e = fl;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            d = model(ins, CFG_M[k], CFG_J[k], CFG_U[k]);
            if (r) begin
                exp_e[k] = '0;
                exp_cnt[k] = 0;
            end else if (fl) begin
                exp_e[k] = '0;
            end else if (!st) begin
                if (!v)         exp_e[k] = '0;
                else if (d.ill) exp_e[k] = 18'b11;
                else exp_e[k] = {d.rw, d.asrc, d.asrca, d.mw, d.res, d.br, d.jmp, d.jalr, d.bt, d.alu, 2'b10};
                if (v && d.ill && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_tests += 2;
            if (obs_e[k] !== 18'h0) begin
                n_fail++; $display("FAIL reset_e dut%0d got %h want 0", k, obs_e[k]);
            end
            if (obs_cnt[k] !== 0) begin
                n_fail++; $display("FAIL reset_cnt dut%0d got %0d want 0", k, obs_cnt[k]);
            end
        end
    endtask

    task automatic test_streams();
        logic [31:0] seq [8];
        logic [3:0]  alu_want [7];
        dec_t d;
        seq[0] = mk(7'h00, 3'd0, 7'h33);
        seq[1] = mk(7'h20, 3'd0, 7'h33);
        seq[2] = mk(7'h20, 3'd5, 7'h33);
        seq[3] = {20'($urandom), 5'($urandom), 7'h37};
        seq[4] = {20'($urandom), 5'($urandom), 7'h17};
        seq[5] = mk(7'($urandom), 3'd0, 7'h67);
        seq[6] = mk(7'($urandom), 3'd6, 7'h63);
        seq[7] = 32'h02000033;
        alu_want = '{4'h0, 4'h1, 4'h9, 4'hA, 4'h0, 4'h0, 4'h6};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, seq[i], 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                d = model(instr_d, CFG_M[k], CFG_J[k], CFG_U[k]);
                n_tests += 3;
                if (obs_e[k] !== exp_e[k]) begin
                    n_fail++; $display("FAIL stream%0d_e dut%0d got %h want %h", i, k, obs_e[k], exp_e[k]);
                end
                if (obs_imm[k] !== d.imm) begin
                    n_fail++; $display("FAIL stream%0d_imm dut%0d got %0d want %0d", i, k, obs_imm[k], d.imm);
                end
                if (obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++; $display("FAIL stream%0d_cnt dut%0d got %0d want %0d", i, k, obs_cnt[k], exp_cnt[k]);
                end
            end
            if (i < 7) begin
                n_tests++;
                if (obs_e[0][5:2] !== alu_want[i]) begin
                    n_fail++; $display("FAIL stream%0d_alu got %h want %h", i, obs_e[0][5:2], alu_want[i]);
                end
            end
        end
        n_tests += 3;
        if (obs_e[0][0] !== 1'b1 || obs_e[0][17] !== 1'b0) begin
            n_fail++; $display("FAIL mul_off got ill=%b rw=%b want ill=1 rw=0", obs_e[0][0], obs_e[0][17]);
        end
        if (obs_e[2][5:2] !== 4'hB || obs_e[2][17] !== 1'b1) begin
            n_fail++; $display("FAIL mul_on got alu=%h rw=%b want alu=b rw=1", obs_e[2][5:2], obs_e[2][17]);
        end
        if (obs_cnt[0] !== 1) begin
            n_fail++; $display("FAIL mul_off_cnt got %0d want 1", obs_cnt[0]);
        end
    endtask

    task automatic test_stall_flush();
        step(1'b0, mk(7'($urandom), 3'd2, 7'h03), 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_e[0] !== {4'b1100, 2'b01, 6'b0, 4'h0, 2'b10}) begin
            n_fail++; $display("FAIL lw_load got %h want %h", obs_e[0], {4'b1100, 2'b01, 6'b0, 4'h0, 2'b10});
        end
        for (int c = 0; c < 4; c++) begin
            if (c < 3) step(1'b0, rand_instr(), 1'b1, 1'b1, 1'b0);
            else       step(1'b0, rand_instr(), 1'b1, 1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                n_tests += 2;
                if (obs_e[k] !== exp_e[k]) begin
                    n_fail++; $display("FAIL stall%0d_e dut%0d got %h want %h", c, k, obs_e[k], exp_e[k]);
                end
                if (obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++; $display("FAIL stall%0d_cnt dut%0d got %0d want %0d", c, k, obs_cnt[k], exp_cnt[k]);
                end
            end
        end
        n_tests++;
        if (obs_e[1] !== 18'h0) begin
            n_fail++; $display("FAIL stall_flush_bubble got %h want 0", obs_e[1]);
        end
    endtask

    task automatic test_saturation();
        int want [5];
        want = '{1, 2, 3, 3, 3};
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0000007F, 1'b1, 1'b0, 1'b0);
            n_tests += 2;
            if (obs_cnt[1] !== want[i]) begin
                n_fail++; $display("FAIL sat%0d got %0d want %0d", i, obs_cnt[1], want[i]);
            end
            if (obs_cnt[0] !== exp_cnt[0]) begin
                n_fail++; $display("FAIL sat%0d_wide got %0d want %0d", i, obs_cnt[0], exp_cnt[0]);
            end
        end
        step(1'b0, 32'h0000007F, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0000007F, 1'b1, 1'b1, 1'b0);
        n_tests += 2;
        if (obs_cnt[0] !== 5) begin
            n_fail++; $display("FAIL ill_flush_stall_cnt got %0d want 5", obs_cnt[0]);
        end
        if (obs_e[0] !== 18'h0) begin
            n_fail++; $display("FAIL ill_flush_stall_e got %h want 0", obs_e[0]);
        end
        step(1'b0, 32'h0000007F, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_tests += 2;
            if (obs_e[k] !== 18'h0) begin
                n_fail++; $display("FAIL invalid_ill_e dut%0d got %h want 0", k, obs_e[k]);
            end
            if (obs_cnt[k] !== exp_cnt[k]) begin
                n_fail++; $display("FAIL invalid_ill_cnt dut%0d got %0d want %0d", k, obs_cnt[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1'b0, mk(7'h00, 3'd7, 7'h33), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0000007F, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h0000007F, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_tests += 2;
            if (obs_e[k] !== 18'h0) begin
                n_fail++; $display("FAIL rst_stall_e dut%0d got %h want 0", k, obs_e[k]);
            end
            if (obs_cnt[k] !== 0) begin
                n_fail++; $display("FAIL rst_stall_cnt dut%0d got %0d want 0", k, obs_cnt[k]);
            end
        end
    endtask

    task automatic test_random();
        dec_t d;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), rand_instr(), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            for (int k = 0; k < 3; k++) begin
                d = model(instr_d, CFG_M[k], CFG_J[k], CFG_U[k]);
                n_tests += 3;
                if (obs_e[k] !== exp_e[k]) begin
                    n_fail++; $display("FAIL rand%0d_e dut%0d instr %h got %h want %h", i, k, instr_d, obs_e[k], exp_e[k]);
                end
                if (obs_imm[k] !== d.imm) begin
                    n_fail++; $display("FAIL rand%0d_imm dut%0d instr %h got %0d want %0d", i, k, instr_d, obs_imm[k], d.imm);
                end
                if (obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++; $display("FAIL rand%0d_cnt dut%0d got %0d want %0d", i, k, obs_cnt[k], exp_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streams();
        test_stall_flush();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
